// File: rtl/lcd_spi_rx_if.sv
// Pin-level SPI inputs and decoded outputs of the LCD SPI receiver.
// The master modport is the LCD host side; the slave modport is the receiver.
interface lcd_spi_rx_if;
  logic        lcd_cs_in;
  logic        lcd_clk_in;
  logic        lcd_data_in;
  logic        lcd_dc_in;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic        pix_we;
  logic [7:0]  pix_x;
  logic [7:0]  pix_y;
  logic [15:0] pix_data;
  logic        disp_on;
  logic        sleep_n;

  modport master (
    output lcd_cs_in, lcd_clk_in, lcd_data_in, lcd_dc_in,
    input  cmd_valid, cmd_code, pix_we, pix_x, pix_y, pix_data, disp_on, sleep_n
  );

  modport slave (
    input  lcd_cs_in, lcd_clk_in, lcd_data_in, lcd_dc_in,
    output cmd_valid, cmd_code, pix_we, pix_x, pix_y, pix_data, disp_on, sleep_n
  );
endinterface

// File: rtl/lcd_spi_rx.sv
// SPI LCD controller receiver: deserialises SPI bytes and decodes CASET/RASET/RAMWR into pixel writes.
// Optional feature LCD_RX_BYTE_TIMEOUT_EN discards a partial byte after TIMEOUT_CYC idle clk cycles.
module lcd_spi_rx #(
  parameter logic [7:0]  LCD_W       = 8'd132,
  parameter logic [7:0]  LCD_H       = 8'd162,
  parameter logic [15:0] TIMEOUT_CYC = 16'd1024
) (
  input logic        clk,
  input logic        rst_n_in,
  lcd_spi_rx_if.slave bus
);

  localparam logic [7:0] LAST_X = LCD_W - 8'd1;
  localparam logic [7:0] LAST_Y = LCD_H - 8'd1;

  typedef enum logic [2:0] {
    CMD,
    CASET_P,
    RASET_P,
    RAMWR,
    SKIP
  } state_e;

  logic [1:0]  csSync_q, sclSync_q, sdaSync_q, dcSync_q;
  logic        sclPrev_q;
  logic        sclRise, csLow;

  logic [2:0]  bitCnt_q, bitCnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        byteValid_q, byteValid_d;
  logic        byteDc_q, byteDc_d;

  state_e      state_q, state_d;
  logic [1:0]  paramCnt_q, paramCnt_d;
  logic [7:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic [7:0]  hi_q, hi_d;
  logic        hiValid_q, hiValid_d;
  logic        cmdValid_q, cmdValid_d;
  logic [7:0]  cmdCode_q, cmdCode_d;
  logic        pixWe_q, pixWe_d;
  logic [7:0]  pixX_q, pixX_d, pixY_q, pixY_d;
  logic [15:0] pixData_q, pixData_d;
  logic        dispOn_q, dispOn_d;
  logic        sleepN_q, sleepN_d;

  logic [7:0]  xeClamp, xeNew, yeClamp, yeNew;

`ifdef LCD_RX_BYTE_TIMEOUT_EN
  logic [15:0] idleCnt_q, idleCnt_d;
`else
  logic        unusedTimeout;
  assign unusedTimeout = ^TIMEOUT_CYC;
`endif

  // Two-flop synchronizers on every SPI pin; SCL edge detect runs on the synchronized copy
  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      csSync_q  <= '0;
      sclSync_q <= '0;
      sdaSync_q <= '0;
      dcSync_q  <= '0;
      sclPrev_q <= 1'b0;
    end else begin
      csSync_q  <= {csSync_q[0],  bus.lcd_cs_in};
      sclSync_q <= {sclSync_q[0], bus.lcd_clk_in};
      sdaSync_q <= {sdaSync_q[0], bus.lcd_data_in};
      dcSync_q  <= {dcSync_q[0],  bus.lcd_dc_in};
      sclPrev_q <= sclSync_q[1];
    end
  end

  assign sclRise = sclSync_q[1] & ~sclPrev_q;
  assign csLow   = ~csSync_q[1];

  always_comb begin
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    byteValid_d = 1'b0;
    byteDc_d    = byteDc_q;
`ifdef LCD_RX_BYTE_TIMEOUT_EN
    idleCnt_d   = '0;
`endif
    if (!csLow) begin
      bitCnt_d = '0;
    end else if (sclRise) begin
      shift_d = {shift_q[6:0], sdaSync_q[1]};
      if (bitCnt_q == 3'd7) begin
        byteValid_d = 1'b1;
        byteDc_d    = dcSync_q[1];
        bitCnt_d    = '0;
      end else begin
        bitCnt_d = bitCnt_q + 3'd1;
      end
    end
`ifdef LCD_RX_BYTE_TIMEOUT_EN
    else if (bitCnt_q != 3'd0) begin
      if (idleCnt_q == TIMEOUT_CYC - 16'd1) begin
        bitCnt_d = '0;
      end else begin
        idleCnt_d = idleCnt_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      bitCnt_q    <= '0;
      shift_q     <= '0;
      byteValid_q <= 1'b0;
      byteDc_q    <= 1'b0;
`ifdef LCD_RX_BYTE_TIMEOUT_EN
      idleCnt_q   <= '0;
`endif
    end else begin
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      byteValid_q <= byteValid_d;
      byteDc_q    <= byteDc_d;
`ifdef LCD_RX_BYTE_TIMEOUT_EN
      idleCnt_q   <= idleCnt_d;
`endif
    end
  end

  // End coordinates clamp to the panel edge, and never fall below the start coordinate
  assign xeClamp = (shift_q > LAST_X) ? LAST_X : shift_q;
  assign xeNew   = (xs_q > xeClamp) ? xs_q : xeClamp;
  assign yeClamp = (shift_q > LAST_Y) ? LAST_Y : shift_q;
  assign yeNew   = (ys_q > yeClamp) ? ys_q : yeClamp;

  always_comb begin
    state_d    = state_q;
    paramCnt_d = paramCnt_q;
    xs_d       = xs_q;
    xe_d       = xe_q;
    ys_d       = ys_q;
    ye_d       = ye_q;
    x_d        = x_q;
    y_d        = y_q;
    hi_d       = hi_q;
    hiValid_d  = hiValid_q;
    cmdValid_d = 1'b0;
    cmdCode_d  = cmdCode_q;
    pixWe_d    = 1'b0;
    pixX_d     = pixX_q;
    pixY_d     = pixY_q;
    pixData_d  = pixData_q;
    dispOn_d   = dispOn_q;
    sleepN_d   = sleepN_q;

    if (byteValid_q && !byteDc_q) begin
      cmdValid_d = 1'b1;
      cmdCode_d  = shift_q;
      hiValid_d  = 1'b0;
      paramCnt_d = '0;
      state_d    = SKIP;
      case (shift_q)
        8'h2A: state_d = CASET_P;
        8'h2B: state_d = RASET_P;
        8'h2C: begin
          state_d = RAMWR;
          x_d     = xs_q;
          y_d     = ys_q;
        end
        8'h10: sleepN_d = 1'b0;
        8'h11: sleepN_d = 1'b1;
        8'h28: dispOn_d = 1'b0;
        8'h29: dispOn_d = 1'b1;
        default: ;
      endcase
    end else if (byteValid_q) begin
      case (state_q)
        CASET_P: begin
          paramCnt_d = paramCnt_q + 2'd1;
          if (paramCnt_q == 2'd1) xs_d = shift_q;
          if (paramCnt_q == 2'd3) begin
            xe_d    = xeNew;
            state_d = SKIP;
          end
        end
        RASET_P: begin
          paramCnt_d = paramCnt_q + 2'd1;
          if (paramCnt_q == 2'd1) ys_d = shift_q;
          if (paramCnt_q == 2'd3) begin
            ye_d    = yeNew;
            state_d = SKIP;
          end
        end
        RAMWR: begin
          if (!hiValid_q) begin
            hi_d      = shift_q;
            hiValid_d = 1'b1;
          end else begin
            hiValid_d = 1'b0;
            pixWe_d   = 1'b1;
            pixData_d = {hi_q, shift_q};
            pixX_d    = x_q;
            pixY_d    = y_q;
            // Raster walk inside the window, wrapping back to the top-left corner
            if (x_q == xe_q) begin
              x_d = xs_q;
              y_d = (y_q == ye_q) ? ys_q : y_q + 8'd1;
            end else begin
              x_d = x_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      state_q    <= CMD;
      paramCnt_q <= '0;
      xs_q       <= '0;
      xe_q       <= LAST_X;
      ys_q       <= '0;
      ye_q       <= LAST_Y;
      x_q        <= '0;
      y_q        <= '0;
      hi_q       <= '0;
      hiValid_q  <= 1'b0;
      cmdValid_q <= 1'b0;
      cmdCode_q  <= 8'h00;
      pixWe_q    <= 1'b0;
      pixX_q     <= '0;
      pixY_q     <= '0;
      pixData_q  <= 16'h0000;
      dispOn_q   <= 1'b0;
      sleepN_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      paramCnt_q <= paramCnt_d;
      xs_q       <= xs_d;
      xe_q       <= xe_d;
      ys_q       <= ys_d;
      ye_q       <= ye_d;
      x_q        <= x_d;
      y_q        <= y_d;
      hi_q       <= hi_d;
      hiValid_q  <= hiValid_d;
      cmdValid_q <= cmdValid_d;
      cmdCode_q  <= cmdCode_d;
      pixWe_q    <= pixWe_d;
      pixX_q     <= pixX_d;
      pixY_q     <= pixY_d;
      pixData_q  <= pixData_d;
      dispOn_q   <= dispOn_d;
      sleepN_q   <= sleepN_d;
    end
  end

  assign bus.cmd_valid = cmdValid_q;
  assign bus.cmd_code  = cmdCode_q;
  assign bus.pix_we    = pixWe_q;
  assign bus.pix_x     = pixX_q;
  assign bus.pix_y     = pixY_q;
  assign bus.pix_data  = pixData_q;
  assign bus.disp_on   = dispOn_q;
  assign bus.sleep_n   = sleepN_q;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Directed bench for lcd_spi_rx: drives SPI pins on the falling clk edge and checks
// strobes exactly 4 clk cycles after the 8th SCL rise, plus decoded window/pixel state.
module tb_lcd_spi_rx;

  logic clk = 1'b0;
  logic rst_n_in;
  int   totalCnt = 0;
  int   badCnt = 0;

  lcd_spi_rx_if bus ();

  lcd_spi_rx dut (
    .clk      (clk),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  always #5 clk = ~clk;

`ifdef LCD_RX_BYTE_TIMEOUT_EN
  localparam logic       TMO_STROBE = 1'b1;
  localparam logic [7:0] TMO_CODE   = 8'h28;
  localparam logic       TMO_DISP   = 1'b0;
`else
  // Three stale bits plus the first five of 0x28 complete the byte 0xE5 early
  localparam logic       TMO_STROBE = 1'b0;
  localparam logic [7:0] TMO_CODE   = 8'hE5;
  localparam logic       TMO_DISP   = 1'b1;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCnt++;
    if (observed !== expected) begin
      badCnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic shiftBit(input logic b);
    @(negedge clk);
    bus.lcd_data_in = b;
    bus.lcd_clk_in  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.lcd_clk_in  = 1'b1;
    @(negedge clk);
  endtask

  // Sends one byte and checks the strobes one cycle before, at, and one cycle after the 4-cycle point
  task automatic applyStimulus(input string tag, input logic [7:0] value, input logic dc,
                               input logic expCmd, input logic expWe);
    bus.lcd_dc_in = dc;
    for (int i = 7; i >= 0; i--) shiftBit(value[i]);
    @(negedge clk);
    bus.lcd_clk_in = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_early"}, 32'({bus.cmd_valid, bus.pix_we}), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_strobe"}, 32'({bus.cmd_valid, bus.pix_we}), 32'({expCmd, expWe}));
    @(negedge clk);
    checkOutput({tag, "_end"}, 32'({bus.cmd_valid, bus.pix_we}), 32'd0);
  endtask

  task automatic sendCmd(input string tag, input logic [7:0] value);
    applyStimulus(tag, value, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic sendData(input string tag, input logic [7:0] value);
    applyStimulus(tag, value, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic sendPixel(input string tag, input logic [15:0] value,
                           input logic [7:0] expX, input logic [7:0] expY);
    sendData({tag, "_hi"}, value[15:8]);
    applyStimulus({tag, "_lo"}, value[7:0], 1'b1, 1'b0, 1'b1);
    checkOutput({tag, "_x"}, 32'(bus.pix_x), 32'(expX));
    checkOutput({tag, "_y"}, 32'(bus.pix_y), 32'(expY));
    checkOutput({tag, "_data"}, 32'(bus.pix_data), 32'(value));
  endtask

  task automatic resetAndCheck(input string tag);
    rst_n_in        = 1'b0;
    bus.lcd_cs_in   = 1'b1;
    bus.lcd_clk_in  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput({tag, "_strobes"}, 32'({bus.cmd_valid, bus.pix_we}), 32'd0);
    checkOutput({tag, "_code"}, 32'(bus.cmd_code), 32'h00);
    checkOutput({tag, "_pix"}, {bus.pix_x, bus.pix_y, bus.pix_data}, 32'd0);
    checkOutput({tag, "_flags"}, 32'({bus.disp_on, bus.sleep_n}), 32'd0);
    rst_n_in = 1'b1;
    @(negedge clk);
    bus.lcd_cs_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulseCs();
    @(negedge clk);
    bus.lcd_cs_in  = 1'b1;
    bus.lcd_clk_in = 1'b0;
    repeat (4) @(negedge clk);
    bus.lcd_cs_in  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] wrapX [5];
    logic [7:0] wrapY [5];
    wrapX = '{8'd128, 8'd129, 8'd130, 8'd131, 8'd128};
    wrapY = '{8'd10, 8'd10, 8'd10, 8'd10, 8'd11};

    rst_n_in        = 1'b0;
    bus.lcd_cs_in   = 1'b1;
    bus.lcd_clk_in  = 1'b0;
    bus.lcd_data_in = 1'b0;
    bus.lcd_dc_in   = 1'b0;
    resetAndCheck("rst0");

    $display("[TB] display on");
    sendCmd("dispon", 8'h29);
    checkOutput("dispon_code", 32'(bus.cmd_code), 32'h29);
    checkOutput("dispon_flag", 32'(bus.disp_on), 32'd1);

    $display("[TB] small window raster");
    sendCmd("caset", 8'h2A);
    sendData("cs0", 8'h00); sendData("cs1", 8'h02); sendData("cs2", 8'h00); sendData("cs3", 8'h03);
    sendCmd("raset", 8'h2B);
    sendData("rs0", 8'h00); sendData("rs1", 8'h05); sendData("rs2", 8'h00); sendData("rs3", 8'h05);
    sendCmd("ramwr", 8'h2C);
    sendPixel("p0", 16'hF800, 8'd2, 8'd5);
    sendPixel("p1", 16'h07E0, 8'd3, 8'd5);
    sendPixel("p2", 16'h001F, 8'd2, 8'd5);

    $display("[TB] clamped window walk");
    sendCmd("caset2", 8'h2A);
    sendData("cc0", 8'h00); sendData("cc1", 8'h80); sendData("cc2", 8'h00); sendData("cc3", 8'hFF);
    sendCmd("raset2", 8'h2B);
    sendData("rr0", 8'h00); sendData("rr1", 8'h0A); sendData("rr2", 8'h00); sendData("rr3", 8'h0B);
    sendCmd("ramwr2", 8'h2C);
    for (int k = 0; k < 5; k++) sendPixel($sformatf("wrap%0d", k), 16'hFFE0, wrapX[k], wrapY[k]);

    $display("[TB] orphan high byte");
    sendCmd("ramwr3", 8'h2C);
    sendData("orphan", 8'hFF);
    sendCmd("nop", 8'h00);
    sendCmd("ramwr4", 8'h2C);
    sendPixel("after", 16'h1234, 8'd128, 8'd10);

    $display("[TB] partial byte cleared by chip select");
    for (int i = 0; i < 5; i++) shiftBit(i[0]);
    pulseCs();
    checkOutput("sleep_before", 32'(bus.sleep_n), 32'd0);
    sendCmd("wake", 8'h11);
    checkOutput("wake_code", 32'(bus.cmd_code), 32'h11);
    checkOutput("wake_flag", 32'(bus.sleep_n), 32'd1);

    $display("[TB] idle gap inside a byte");
    for (int i = 0; i < 3; i++) shiftBit(1'b1);
    repeat (1100) @(negedge clk);
    applyStimulus("tmo", 8'h28, 1'b0, TMO_STROBE, 1'b0);
    checkOutput("tmo_code", 32'(bus.cmd_code), 32'(TMO_CODE));
    checkOutput("tmo_disp", 32'(bus.disp_on), 32'(TMO_DISP));
    pulseCs();

    $display("[TB] reset mid-pixel and mid-byte");
    sendCmd("ramwr5", 8'h2C);
    sendData("pend", 8'hAB);
    shiftBit(1'b1); shiftBit(1'b0); shiftBit(1'b1);
    resetAndCheck("rst1");
    sendCmd("post", 8'h29);
    checkOutput("post_code", 32'(bus.cmd_code), 32'h29);
    sendCmd("ramwr6", 8'h2C);
    sendPixel("origin", 16'h1234, 8'd0, 8'd0);

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule

// File: doc/lcd_spi_rx.md
LCD_SPI_RX -- requirements
Module: lcd_spi_rx

Interface
REQ-001 SHALL have parameter LCD_W, default 8'd132, meaning screen width in pixels.
REQ-002 SHALL have parameter LCD_H, default 8'd162, meaning screen height in pixels.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16'd1024, meaning SCL idle clk cycles before a partial byte is discarded.
REQ-004 SHALL have ports:
- clk  in  1  system clock, 100 MHz; one clock domain, all logic on posedge.
- rst_n_in  in  1  reset, synchronous and active-low.
- lcd_cs_in  in  1  SPI chip select, active low.
- lcd_clk_in  in  1  SPI SCL; data is sampled on its rising edge.
- lcd_data_in  in  1  SPI SDA, MSB first.
- lcd_dc_in  in  1  0 = command byte, 1 = data byte.
- cmd_valid  out  1  one-cycle pulse when a command byte is received.
- cmd_code  out  8  last command byte received.
- pix_we  out  1  one-cycle pixel write strobe.
- pix_x  out  8  pixel column.
- pix_y  out  8  pixel row.
- pix_data  out  16  RGB565 pixel value.
- disp_on  out  1  display-on flag.
- sleep_n  out  1  0 = sleep, 1 = awake.

Function
REQ-005 SHALL pass lcd_cs_in, lcd_clk_in, lcd_data_in and lcd_dc_in through 2-FF synchronizers, then rising-edge-detect SCL on the synchronized copy.
REQ-006 SHALL shift in SDA on each detected SCL rise while synchronized CS is low, and ignore SCL rises while CS is high.
REQ-007 SHALL complete a byte on the 8th bit, taking DC from its value sampled at that 8th edge.
REQ-008 SHALL drive byte-level outputs (cmd_valid, pix_we) exactly 4 clk cycles after the 8th SCL rise at the pins.
REQ-009 SHALL clear the bit counter and discard the partial byte when CS is high; decoder state is retained.
REQ-010 SHALL accept SCL high and low phases of 1 clk cycle minimum each.
REQ-011 SHALL implement decoder FSM states CMD, CASET_P, RASET_P, RAMWR, SKIP, with a 2-bit parameter counter.
REQ-012 On any command byte, in any state, the FSM SHALL:
- pulse cmd_valid and load cmd_code;
- drop any pending pixel high byte;
- reset the parameter counter;
- transition by code: 0x2A -> CASET_P; 0x2B -> RASET_P; 0x2C -> RAMWR; everything else -> SKIP.
REQ-013 SHALL set sleep_n for 0x11 and clear it for 0x10, and SHALL set disp_on for 0x29 and clear it for 0x28; these four codes are followed by SKIP.
REQ-014 In CASET_P, parameter bytes 0..3 SHALL be XS_hi, XS_lo, XE_hi, XE_lo; hi bytes are ignored, and after byte 3 the FSM goes to SKIP.
REQ-015 SHALL clamp XE to LCD_W-1; if XS > XE, XE SHALL be taken equal to XS; RASET_P SHALL be identical using YS/YE and LCD_H-1.
REQ-016 Entering RAMWR SHALL load the column counter with XS and the row counter with YS.
REQ-017 In RAMWR, even data bytes SHALL be latched as the pixel high byte, and each odd data byte SHALL complete a pixel: pix_data = {hi, lo}, pix_x/pix_y = current counters, pix_we pulses for 1 cycle.
REQ-018 After each pixel write, if x == XE the FSM SHALL set x = XS and advance y; if y == YE, y SHALL wrap to YS; otherwise x SHALL increment.
REQ-019 In SKIP and CMD, data bytes SHALL be ignored with no output.
REQ-020 pix_x, pix_y and pix_data SHALL hold their values between strobes.

Reset
REQ-021 While rst_n_in = 0 at a clk edge, the block SHALL set:
- cmd_valid = 0, pix_we = 0;
- cmd_code = 8'h00, pix_x = 0, pix_y = 0, pix_data = 16'h0000;
- disp_on = 0, sleep_n = 0;
- FSM = CMD;
- window XS = 0, XE = LCD_W-1, YS = 0, YE = LCD_H-1;
- bit counter and synchronizers cleared.
REQ-022 A reset mid-byte or mid-pixel SHALL discard the partial data with no strobe issued.

Configuration
REQ-023 With LCD_RX_BYTE_TIMEOUT_EN defined, the block SHALL discard any partial byte (bit counter cleared) when no SCL rise is seen for TIMEOUT_CYC clk cycles while the bit counter is non-zero; a pending pixel high byte is kept.
REQ-024 Without LCD_RX_BYTE_TIMEOUT_EN, partial bytes SHALL persist until CS goes high or reset; the timeout counter SHALL be absent.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset, then send cmd 0x29 -> cmd_valid pulse, cmd_code = 0x29, disp_on = 1, 4 cycles after the 8th SCL rise.
- CASET 00 02 00 03, RASET 00 05 00 05, RAMWR, then 6 data bytes F8 00 07 E0 00 1F -> pix_we at (2,5) = F800, (3,5) = 07E0, (2,5) = 001F.
- CASET 00 80 00 FF, then RAMWR and pixel FFE0 -> XE clamped to 131; pixels walk x = 128..131 then wrap to x = 128 and advance y.
- RAMWR, byte FF, then cmd 0x00, then RAMWR and bytes 12 34 -> no pixel from the orphan FF; one pixel 1234 at (XS,YS).
- 5 bits shifted, then CS high, then full byte 0x11 -> cmd_code = 0x11, sleep_n = 1.
- With LCD_RX_BYTE_TIMEOUT_EN: 3 bits, 1100 idle cycles, then byte 0x28 -> cmd_code = 0x28, disp_on = 0; without the macro the same stimulus yields a misaligned byte.
